// File: rtl/pkt_pkg.sv
// pkt_pkg: shared constants and state encoding for the pkt_responder block.
//   SOF/ACK/NAK      framing and status bytes
//   CMD_PING/ECHO    recognised command codes
//   state_t          protocol engine state encoding
//   umax             constant helper used to size shared counters
package pkt_pkg;

    localparam logic [7:0] SOF      = 8'hA5;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;
    localparam logic [7:0] CMD_PING = 8'h01;
    localparam logic [7:0] CMD_ECHO = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pkt_gap_timer.sv
// pkt_gap_timer: loadable down-counter that stops at zero.
//   clk, rst_n     clock, async active-low reset
//   i_load         load i_load_val this cycle (wins over counting)
//   i_load_val     reload value; expiry is seen i_load_val+1 cycles after load
//   o_expired_c    combinational: counter is at zero
module pkt_gap_timer #(
    parameter int unsigned MAX_CNT = 86900,
    parameter int unsigned CNT_W   = ($clog2(MAX_CNT) > 0) ? $clog2(MAX_CNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired_c
);

    logic [CNT_W-1:0] r_cnt;

    // Count down and park at zero until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/pkt_responder.sv
// pkt_responder: frames command packets from the receive byte stream and
// answers each with a framed response paced at a fixed inter-byte gap.
//   clk, rst_n           clock, async active-low reset
//   rx_byte, rx_valid    received byte and its single-cycle strobe
//   tx_byte, tx_valid    response byte (held between strobes) and strobe
//   busy                 high from SOF accept until last response strobe
//   err                  single-cycle pulse on a frame error
// Optional: define PKT_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CLKS cycles without a received byte.
module pkt_responder
    import pkt_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TX_GAP_CLKS  = 8690,
    parameter int unsigned TIMEOUT_CLKS = 86900
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic       busy,
    output logic       err
);

    localparam int unsigned TMR_MAX = umax(TX_GAP_CLKS, TIMEOUT_CLKS);
    localparam int unsigned TMR_W   = ($clog2(TMR_MAX) > 0) ? $clog2(TMR_MAX) : 1;
    localparam int unsigned BUF_AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned IDX_W   = $clog2(MAX_LEN + 5);

    state_t             r_state;
    logic [7:0]         r_cmd;
    logic [7:0]         r_len;
    logic [7:0]         r_idx;
    logic [7:0]         r_rx_csum;
    logic [7:0]         r_status;
    logic [7:0]         r_resp_len;
    logic [IDX_W-1:0]   r_tx_idx;
    logic [7:0]         r_tx_csum;
    logic [7:0]         r_tx_byte;
    logic               r_tx_valid;
    logic               r_busy;
    logic               r_err;
    logic [7:0]         r_buf [MAX_LEN];

    state_t             w_state_nxt;
    logic [7:0]         w_cmd_nxt;
    logic [7:0]         w_len_nxt;
    logic [7:0]         w_idx_nxt;
    logic [7:0]         w_rx_csum_nxt;
    logic [7:0]         w_status_nxt;
    logic [7:0]         w_resp_len_nxt;
    logic [IDX_W-1:0]   w_tx_idx_nxt;
    logic [7:0]         w_tx_csum_nxt;
    logic [7:0]         w_tx_byte_nxt;
    logic               w_tx_valid_nxt;
    logic               w_busy_nxt;
    logic               w_err_nxt;
    logic               w_buf_we;
    logic [BUF_AW-1:0]  w_buf_waddr;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_expired;
    logic [IDX_W-1:0]   w_tx_total;
    logic [7:0]         w_tx_sel;

    // One timer serves TX pacing and, when enabled, the RX inter-byte timeout;
    // the two uses never overlap because the engine is half-duplex.
    pkt_gap_timer #(
        .MAX_CNT (TMR_MAX),
        .CNT_W   (TMR_W)
    ) u_gap_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_tmr_load),
        .i_load_val  (w_tmr_val),
        .o_expired_c (w_tmr_expired)
    );

    assign w_tx_total = IDX_W'(r_resp_len) + IDX_W'(4);

    // Response byte at index r_tx_idx: STATUS, LEN, payload..., CSUM.
    always_comb begin
        w_tx_sel = r_tx_csum;
        if (r_tx_idx == IDX_W'(1)) begin
            w_tx_sel = r_status;
        end else if (r_tx_idx == IDX_W'(2)) begin
            w_tx_sel = r_resp_len;
        end else if (r_tx_idx < w_tx_total - IDX_W'(1)) begin
            w_tx_sel = r_buf[BUF_AW'(r_tx_idx - IDX_W'(3))];
        end
    end

    // Next-state and output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_nxt      = r_cmd;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_rx_csum_nxt  = r_rx_csum;
        w_status_nxt   = r_status;
        w_resp_len_nxt = r_resp_len;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_csum_nxt  = r_tx_csum;
        w_tx_byte_nxt  = r_tx_byte;
        w_tx_valid_nxt = 1'b0;
        w_busy_nxt     = r_busy;
        w_err_nxt      = 1'b0;
        w_buf_we       = 1'b0;
        w_buf_waddr    = BUF_AW'(r_idx);
        w_tmr_load     = 1'b0;
        w_tmr_val      = TMR_W'(TIMEOUT_CLKS - 1);

        case (r_state)
            ST_IDLE: begin
                if (rx_valid && (rx_byte == SOF)) begin
                    w_state_nxt   = ST_CMD;
                    w_busy_nxt    = 1'b1;
                    w_rx_csum_nxt = 8'h00;
                    w_idx_nxt     = 8'h00;
                    w_tmr_load    = 1'b1;
                end
            end
            ST_CMD: begin
                if (rx_valid) begin
                    w_state_nxt   = ST_LEN;
                    w_cmd_nxt     = rx_byte;
                    w_rx_csum_nxt = r_rx_csum ^ rx_byte;
                    w_tmr_load    = 1'b1;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (rx_byte > 8'(MAX_LEN)) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt   = (rx_byte == 8'h00) ? ST_CSUM : ST_DATA;
                        w_len_nxt     = rx_byte;
                        w_rx_csum_nxt = r_rx_csum ^ rx_byte;
                        w_idx_nxt     = 8'h00;
                        w_tmr_load    = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    w_buf_we      = 1'b1;
                    w_rx_csum_nxt = r_rx_csum ^ rx_byte;
                    w_idx_nxt     = r_idx + 8'd1;
                    w_tmr_load    = 1'b1;
                    if (r_idx == r_len - 8'd1) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    w_resp_len_nxt = 8'h00;
                    w_status_nxt   = NAK;
                    if (rx_byte != r_rx_csum) begin
                        w_err_nxt = 1'b1;
                    end else if (r_cmd == CMD_PING) begin
                        w_status_nxt = ACK;
                    end else if (r_cmd == CMD_ECHO) begin
                        w_status_nxt   = ACK;
                        w_resp_len_nxt = r_len;
                    end
                    // SOF goes out immediately; later bytes wait on the timer.
                    w_state_nxt    = ST_RESP;
                    w_tx_byte_nxt  = SOF;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_idx_nxt   = IDX_W'(1);
                    w_tx_csum_nxt  = 8'h00;
                    w_tmr_load     = 1'b1;
                    w_tmr_val      = TMR_W'(TX_GAP_CLKS - 1);
                end
            end
            ST_RESP: begin
                if (r_tx_idx == w_tx_total) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (w_tmr_expired) begin
                    w_tx_byte_nxt  = w_tx_sel;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_csum_nxt  = r_tx_csum ^ w_tx_sel;
                    w_tx_idx_nxt   = r_tx_idx + IDX_W'(1);
                    w_tmr_load     = 1'b1;
                    w_tmr_val      = TMR_W'(TX_GAP_CLKS - 1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

`ifdef PKT_TIMEOUT_EN
        // Abandon a stalled partial frame; the timer was reloaded on every byte.
        if (!rx_valid && w_tmr_expired &&
            (r_state inside {ST_CMD, ST_LEN, ST_DATA, ST_CSUM})) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cmd      <= 8'h00;
            r_len      <= 8'h00;
            r_idx      <= 8'h00;
            r_rx_csum  <= 8'h00;
            r_status   <= 8'h00;
            r_resp_len <= 8'h00;
            r_tx_idx   <= '0;
            r_tx_csum  <= 8'h00;
            r_tx_byte  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd      <= w_cmd_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_rx_csum  <= w_rx_csum_nxt;
            r_status   <= w_status_nxt;
            r_resp_len <= w_resp_len_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_csum  <= w_tx_csum_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Payload storage; contents are only read after being written this frame.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[w_buf_waddr] <= rx_byte;
        end
    end

    assign tx_byte  = r_tx_byte;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_pkt_responder.sv
// tb_pkt_responder: directed self-checking bench for pkt_responder.
// A short TX gap keeps runs brief; the timeout case is built only when
// PKT_TIMEOUT_EN is defined.
module tb_pkt_responder;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned GAP     = 16;
    localparam int unsigned TMO     = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       busy;
    logic       err;

    pkt_responder #(
        .MAX_LEN      (MAX_LEN),
        .TX_GAP_CLKS  (GAP),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed response stream, strobe times, error pulses, busy fall time.
    byte unsigned rxq[$];
    int unsigned  rxt[$];
    int unsigned  err_cnt;
    int unsigned  busy_fall;
    logic         prev_busy = 1'b0;

    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            rxq.push_back(tx_byte);
            rxt.push_back(cyc);
        end
        if (err === 1'b1) err_cnt++;
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
        prev_busy = busy;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    int unsigned s_cyc;
    logic        s_err;

    task automatic send_byte(input byte unsigned b);
        @(posedge clk);
        #1 rx_byte = b; rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        s_cyc = cyc;
        s_err = err;
        repeat (3) @(posedge clk);
    endtask

    task automatic run(input string tag, input byte unsigned cmd[$], input byte unsigned extra[$],
                       input byte unsigned rsp[$], input int unsigned exp_err);
        int unsigned t_rx;
        int unsigned dev;
        int          n;
        rxq.delete();
        rxt.delete();
        err_cnt   = 0;
        busy_fall = 0;
        foreach (cmd[i]) send_byte(cmd[i]);
        t_rx = s_cyc;
        if (exp_err != 0 && cmd.size() >= 3) chk({tag, " err_timing"}, 32'(s_err), 32'd1);
        foreach (extra[i]) send_byte(extra[i]);
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, " done"}, 32'(n < 5000), 32'd1);
        repeat (3 * GAP) @(negedge clk);
        chk({tag, " nbytes"}, rxq.size(), rsp.size());
        for (int i = 0; i < rsp.size() && i < rxq.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(rxq[i]), 32'(rsp[i]));
        chk({tag, " err_cnt"}, err_cnt, exp_err);
        if (rsp.size() > 0 && rxt.size() == rsp.size()) begin
            chk({tag, " first_lat"}, rxt[0], t_rx);
            dev = 0;
            for (int i = 1; i < rxt.size(); i++)
                if (rxt[i] - rxt[i-1] != GAP) dev++;
            chk({tag, " gap"}, dev, 32'd0);
            chk({tag, " busy_fall"}, busy_fall, rxt[rxt.size()-1] + 1);
        end
    endtask

    byte unsigned c[$];
    byte unsigned x[$];
    byte unsigned r[$];

    initial begin
        int n;
        rst_n    = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst tx_byte", 32'(tx_byte), 32'h00);
        chk("rst tx_valid", 32'(tx_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // busy rises the cycle after SOF
        x.delete();
        send_byte(8'hA5);
        chk("busy_rise", 32'(busy), 32'd1);
        c = '{8'h01, 8'h00, 8'h01};
        r = '{8'hA5, 8'h06, 8'h00, 8'h06};
        run("ping_tail", c, x, r, 0);

        c = '{8'hA5, 8'h01, 8'h00, 8'h01};
        run("ping", c, x, r, 0);

        c = '{8'hA5, 8'h02, 8'h02, 8'h11, 8'h22, 8'h33};
        r = '{8'hA5, 8'h06, 8'h02, 8'h11, 8'h22, 8'h37};
        run("echo2", c, x, r, 0);

        c = '{8'hA5, 8'h01, 8'h00, 8'h00};
        r = '{8'hA5, 8'h15, 8'h00, 8'h15};
        run("badcsum", c, x, r, 1);

        c = '{8'hA5, 8'h02, 8'h11};
        r.delete();
        run("overlen", c, x, r, 1);

        c = '{8'hA5, 8'h01, 8'h00, 8'h01};
        r = '{8'hA5, 8'h06, 8'h00, 8'h06};
        run("ping_after_err", c, x, r, 0);

        c = '{8'hA5, 8'h7F, 8'h00, 8'h7F};
        r = '{8'hA5, 8'h15, 8'h00, 8'h15};
        run("unknown", c, x, r, 0);

        // Junk before SOF is discarded.
        c = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01};
        r = '{8'hA5, 8'h06, 8'h00, 8'h06};
        run("junk_ping", c, x, r, 0);

        c = '{8'hA5, 8'h02, 8'h00, 8'h02};
        run("echo0", c, x, r, 0);

        // Max-length echo: XOR of 1..16 is 0x10, so CSUM in 0x02, out 0x06.
        c = '{8'hA5, 8'h02, 8'h10};
        r = '{8'hA5, 8'h06, 8'h10};
        for (int i = 1; i <= 16; i++) begin
            c.push_back(8'(i));
            r.push_back(8'(i));
        end
        c.push_back(8'h02);
        r.push_back(8'h06);
        run("echo16", c, x, r, 0);

        // A full command arriving during the response is ignored.
        c = '{8'hA5, 8'h01, 8'h00, 8'h01};
        x = '{8'hA5, 8'h01, 8'h00, 8'h01};
        r = '{8'hA5, 8'h06, 8'h00, 8'h06};
        run("rx_in_resp", c, x, r, 0);
        x.delete();

`ifdef PKT_TIMEOUT_EN
        c = '{8'hA5, 8'h01};
        r.delete();
        run("timeout", c, x, r, 1);
        c = '{8'hA5, 8'h01, 8'h00, 8'h01};
        r = '{8'hA5, 8'h06, 8'h00, 8'h06};
        run("ping_after_tmo", c, x, r, 0);
`endif

        // Reset while the second response byte is strobing.
        rxq.delete();
        rxt.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        n = 0;
        while (!(tx_valid === 1'b1 && rxq.size() == 1) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_mid reach", 32'(n < 2000), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid busy", 32'(busy), 32'd0);
        chk("rst_mid tx_byte", 32'(tx_byte), 32'h00);
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6 * GAP) @(posedge clk);
        chk("rst_mid no_more", rxq.size(), 32'd1);

        c = '{8'hA5, 8'h01, 8'h00, 8'h01};
        r = '{8'hA5, 8'h06, 8'h00, 8'h06};
        run("ping_after_rst", c, x, r, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
